usb3_ep_pingpong_ctrl: RTL and testbench

//  Ping-pong (two-slot) buffer controller for one bulk IN endpoint of the USB3 protocol layer.

---
 rtl/usb3_ep_pingpong_ctrl_if.sv | 34 +++
 rtl/usb3_ep_pingpong_ctrl.sv | 134 +++++++++++++
 tb/tb_usb3_ep_pingpong_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/usb3_ep_pingpong_ctrl_if.sv
// Handshake bundle between the bulk IN endpoint ping-pong controller,
// the external producer and the link layer.
interface usb3_ep_pingpong_ctrl_if #(
  parameter int LEN_W = 11
);
  logic             ext_commit;
  logic [LEN_W-1:0] ext_commit_len;
  logic             ext_commit_ack;
  logic             ext_ready;
  logic             ext_wr_sel;
  logic             link_arm;
  logic             link_arm_ack;
  logic             link_hasdata;
  logic [LEN_W-1:0] link_len;
  logic             link_rd_sel;
  logic [4:0]       link_seq;
  logic             ep_flush;
  logic             seq_reset;
  logic             err_overrun;
  logic             err_underrun;
  logic             err_len;

  modport master (
    output ext_commit, ext_commit_len, link_arm, ep_flush, seq_reset,
    input  ext_commit_ack, ext_ready, ext_wr_sel, link_arm_ack, link_hasdata,
           link_len, link_rd_sel, link_seq, err_overrun, err_underrun, err_len
  );

  modport slave (
    input  ext_commit, ext_commit_len, link_arm, ep_flush, seq_reset,
    output ext_commit_ack, ext_ready, ext_wr_sel, link_arm_ack, link_hasdata,
           link_len, link_rd_sel, link_seq, err_overrun, err_underrun, err_len
  );
endinterface

// File: rtl/usb3_ep_pingpong_ctrl.sv
// Two-slot ownership sequencer for one bulk IN endpoint: the producer commits
// a half of the endpoint BRAM, the link drains it and arms it back to free.
module usb3_ep_pingpong_ctrl #(
  parameter int LEN_W   = 11,
  parameter int MAX_LEN = 1024
) (
  input  logic                   local_clk,
  input  logic                   reset_n,
  usb3_ep_pingpong_ctrl_if.slave bus
);

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_ACK = 2'd1, C_WAIT = 2'd2} c_state_t;
  typedef enum logic [1:0] {A_IDLE = 2'd0, A_ACK = 2'd1, A_WAIT = 2'd2} a_state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  c_state_t               c_state_reg, c_state_next;
  a_state_t               a_state_reg, a_state_next;
  logic [1:0]             full_reg, full_next;
  logic [1:0][LEN_W-1:0]  len_reg, len_next;
  logic                   wr_ptr_reg, wr_ptr_next;
  logic                   rd_ptr_reg, rd_ptr_next;
  logic [4:0]             seq_reg, seq_next;
  logic                   err_overrun_reg, err_underrun_reg, err_len_reg;
  logic                   commit_ok, commit_ovr, arm_ok, arm_udr;
  logic                   len_too_big;
  logic [LEN_W-1:0]       len_clamped;

  assign len_too_big = (bus.ext_commit_len > MAX_LEN_L);
  assign len_clamped = len_too_big ? MAX_LEN_L : bus.ext_commit_len;

  // Commit and arm both look at pre-edge flags, so a full slot is never
  // handed straight through to a same-cycle commit.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic wr_hit, rd_hit;
      assign wr_hit        = commit_ok && (wr_ptr_reg == 1'(gi));
      assign rd_hit        = arm_ok && (rd_ptr_reg == 1'(gi));
      assign full_next[gi] = bus.ep_flush ? 1'b0 :
                             wr_hit       ? 1'b1 :
                             rd_hit       ? 1'b0 : full_reg[gi];
      assign len_next[gi]  = wr_hit ? len_clamped : len_reg[gi];
    end
  endgenerate

  assign wr_ptr_next = bus.ep_flush ? 1'b0 : (wr_ptr_reg ^ commit_ok);
  assign rd_ptr_next = bus.ep_flush ? 1'b0 : (rd_ptr_reg ^ arm_ok);
  assign seq_next    = bus.seq_reset ? 5'd0 : (seq_reg + 5'(arm_ok));

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      c_state_reg      <= C_IDLE;
      a_state_reg      <= A_IDLE;
      full_reg         <= '0;
      len_reg          <= '0;
      wr_ptr_reg       <= 1'b0;
      rd_ptr_reg       <= 1'b0;
      seq_reg          <= 5'd0;
      err_overrun_reg  <= 1'b0;
      err_underrun_reg <= 1'b0;
      err_len_reg      <= 1'b0;
    end else begin
      c_state_reg      <= c_state_next;
      a_state_reg      <= a_state_next;
      full_reg         <= full_next;
      len_reg          <= len_next;
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      seq_reg          <= seq_next;
      err_overrun_reg  <= commit_ovr;
      err_underrun_reg <= arm_udr;
      err_len_reg      <= commit_ok && len_too_big;
    end
  end

  always_comb begin
    c_state_next = c_state_reg;
    a_state_next = a_state_reg;
    commit_ok    = 1'b0;
    commit_ovr   = 1'b0;
    arm_ok       = 1'b0;
    arm_udr      = 1'b0;
    if (bus.ep_flush) begin
      // Park a still-held request in WAIT so it is not re-accepted after the flush.
      c_state_next = bus.ext_commit ? C_WAIT : C_IDLE;
      a_state_next = bus.link_arm   ? A_WAIT : A_IDLE;
    end else begin
      case (c_state_reg)
        C_IDLE: if (bus.ext_commit) begin
          if (!full_reg[wr_ptr_reg]) begin
            commit_ok    = 1'b1;
            c_state_next = C_ACK;
          end else begin
            commit_ovr   = 1'b1;
            c_state_next = C_WAIT;
          end
        end
        C_ACK:   c_state_next = C_WAIT;
        C_WAIT:  if (!bus.ext_commit) c_state_next = C_IDLE;
        default: c_state_next = C_IDLE;
      endcase
      case (a_state_reg)
        A_IDLE: if (bus.link_arm) begin
          if (full_reg[rd_ptr_reg]) begin
            arm_ok       = 1'b1;
            a_state_next = A_ACK;
          end else begin
            arm_udr      = 1'b1;
            a_state_next = A_WAIT;
          end
        end
        A_ACK:   a_state_next = A_WAIT;
        A_WAIT:  if (!bus.link_arm) a_state_next = A_IDLE;
        default: a_state_next = A_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ext_commit_ack = (c_state_reg == C_ACK);
    bus.link_arm_ack   = (a_state_reg == A_ACK);
    bus.ext_wr_sel     = wr_ptr_reg;
    bus.ext_ready      = ~full_reg[wr_ptr_reg];
    bus.link_rd_sel    = rd_ptr_reg;
    bus.link_hasdata   = full_reg[rd_ptr_reg];
    bus.link_len       = len_reg[rd_ptr_reg];
    bus.link_seq       = seq_reg;
    bus.err_overrun    = err_overrun_reg;
    bus.err_underrun   = err_underrun_reg;
    bus.err_len        = err_len_reg;
  end

endmodule

// File: tb/tb_usb3_ep_pingpong_ctrl.sv
// Directed bench for the ping-pong endpoint controller; every expected value
// below is worked out by hand from the slot/pointer/sequence behaviour.
module tb_usb3_ep_pingpong_ctrl;

  logic local_clk;
  logic reset_n;
  int   n_asserts;
  int   n_fail;
  int   ack_count;

  usb3_ep_pingpong_ctrl_if #(.LEN_W(11)) bus ();

  usb3_ep_pingpong_ctrl #(.LEN_W(11), .MAX_LEN(1024)) dut (
    .local_clk (local_clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  initial local_clk = 1'b0;
  always #5 local_clk = ~local_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-22s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.ext_commit = 1'b0;
    bus.link_arm   = 1'b0;
    bus.ep_flush   = 1'b0;
    bus.seq_reset  = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic commit_req(input int len);
    bus.ext_commit     = 1'b1;
    bus.ext_commit_len = 11'(len);
    tick();
  endtask

  task automatic commit_rel();
    bus.ext_commit = 1'b0;
    tick();
    tick();
  endtask

  task automatic arm_req();
    bus.link_arm = 1'b1;
    tick();
  endtask

  task automatic arm_rel();
    bus.link_arm = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    bus.ext_commit     = 1'b0;
    bus.ext_commit_len = '0;
    bus.link_arm       = 1'b0;
    bus.ep_flush       = 1'b0;
    bus.seq_reset      = 1'b0;
    #2;
    chk("rst_ready", 32'(bus.ext_ready), 1);
    chk("rst_hasdata", 32'(bus.link_hasdata), 0);
    chk("rst_ack", 32'(bus.ext_commit_ack), 0);
    chk("rst_seq", 32'(bus.link_seq), 0);
    do_reset();

    // 1: single commit
    commit_req(512);
    chk("t1_ack", 32'(bus.ext_commit_ack), 1);
    chk("t1_hasdata", 32'(bus.link_hasdata), 1);
    chk("t1_len", 32'(bus.link_len), 512);
    chk("t1_rd_sel", 32'(bus.link_rd_sel), 0);
    chk("t1_wr_sel", 32'(bus.ext_wr_sel), 1);
    chk("t1_ready", 32'(bus.ext_ready), 1);
    bus.ext_commit = 1'b0;
    tick();
    chk("t1_ack_one_cycle", 32'(bus.ext_commit_ack), 0);
    tick();

    // 2: fill both, then overrun, then arm
    do_reset();
    commit_req(100);
    commit_rel();
    commit_req(200);
    chk("t2_ready_full", 32'(bus.ext_ready), 0);
    chk("t2_len_first", 32'(bus.link_len), 100);
    commit_rel();
    commit_req(300);
    chk("t2_overrun", 32'(bus.err_overrun), 1);
    chk("t2_no_ack", 32'(bus.ext_commit_ack), 0);
    commit_rel();
    chk("t2_overrun_pulse", 32'(bus.err_overrun), 0);
    arm_req();
    chk("t2_arm_ack", 32'(bus.link_arm_ack), 1);
    chk("t2_len_second", 32'(bus.link_len), 200);
    chk("t2_seq", 32'(bus.link_seq), 1);
    chk("t2_rd_sel", 32'(bus.link_rd_sel), 1);
    arm_rel();

    // 3: held arm gives one ack, then arm on empty underruns
    ack_count = 0;
    bus.link_arm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.link_arm_ack) ack_count++;
    end
    chk("t3_ack_count", 32'(ack_count), 1);
    chk("t3_seq", 32'(bus.link_seq), 2);
    chk("t3_hasdata", 32'(bus.link_hasdata), 0);
    arm_rel();
    arm_req();
    chk("t3_underrun", 32'(bus.err_underrun), 1);
    chk("t3_no_ack", 32'(bus.link_arm_ack), 0);
    chk("t3_seq_kept", 32'(bus.link_seq), 2);
    arm_rel();

    // 4: one slot full, simultaneous commit and arm
    commit_req(10);
    commit_rel();
    bus.link_arm = 1'b1;
    commit_req(20);
    chk("t4_commit_ack", 32'(bus.ext_commit_ack), 1);
    chk("t4_arm_ack", 32'(bus.link_arm_ack), 1);
    chk("t4_hasdata", 32'(bus.link_hasdata), 1);
    chk("t4_len", 32'(bus.link_len), 20);
    chk("t4_seq", 32'(bus.link_seq), 3);
    bus.link_arm = 1'b0;
    commit_rel();

    // 5: clamp and zero-length packet
    commit_req(1500);
    chk("t5_err_len", 32'(bus.err_len), 1);
    chk("t5_ack", 32'(bus.ext_commit_ack), 1);
    commit_rel();
    chk("t5_err_len_pulse", 32'(bus.err_len), 0);
    arm_req();
    chk("t5_len_clamped", 32'(bus.link_len), 1024);
    chk("t5_seq", 32'(bus.link_seq), 4);
    arm_rel();
    commit_req(0);
    chk("t5_zlp_err_len", 32'(bus.err_len), 0);
    commit_rel();
    arm_req();
    chk("t5_zlp_hasdata", 32'(bus.link_hasdata), 1);
    chk("t5_zlp_len", 32'(bus.link_len), 0);
    arm_rel();

    // 6: sequence wrap, flush, seq_reset, reset mid-ack
    do_reset();
    for (int i = 1; i <= 33; i++) begin
      commit_req(i);
      commit_rel();
      arm_req();
      arm_rel();
      if (i == 31) chk("t6_seq_31", 32'(bus.link_seq), 31);
      if (i == 32) chk("t6_seq_wrap0", 32'(bus.link_seq), 0);
      if (i == 33) chk("t6_seq_wrap1", 32'(bus.link_seq), 1);
    end
    commit_req(7);
    commit_rel();
    commit_req(8);
    commit_rel();
    chk("t6_full_ready", 32'(bus.ext_ready), 0);
    bus.ep_flush = 1'b1;
    tick();
    bus.ep_flush = 1'b0;
    chk("t6_flush_ready", 32'(bus.ext_ready), 1);
    chk("t6_flush_hasdata", 32'(bus.link_hasdata), 0);
    chk("t6_flush_seq", 32'(bus.link_seq), 1);
    chk("t6_flush_wr_sel", 32'(bus.ext_wr_sel), 0);
    bus.seq_reset = 1'b1;
    tick();
    bus.seq_reset = 1'b0;
    chk("t6_seq_reset", 32'(bus.link_seq), 0);
    commit_req(5);
    chk("t6_ack_before_rst", 32'(bus.ext_commit_ack), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_ack_in_rst", 32'(bus.ext_commit_ack), 0);
    chk("t6_hasdata_in_rst", 32'(bus.link_hasdata), 0);
    chk("t6_ready_in_rst", 32'(bus.ext_ready), 1);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_reaccept_ack", 32'(bus.ext_commit_ack), 1);
    chk("t6_reaccept_len", 32'(bus.link_len), 5);
    commit_rel();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
